alu9_rr_scheduler: RTL and testbench

Shares one 9-bit sign-magnitude add/subtract unit between NUM_REQ requesters, such as TPU PE-row accumulators and the bias/offset path.
- Round-robin arbitration; valid/ready on both sides.
- One-entry registered result stage with backpressure.
- Sits between the requesting datapaths and the shared ALU slice.

---
 rtl/alu9_pkg.sv | 19 +
 rtl/sm9_addsub.sv | 68 ++++++
 rtl/alu9_rr_scheduler.sv | 152 +++++++++++++++
 tb/tb_alu9_rr_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu9_pkg.sv
// Shared types and helpers for the 9-bit sign-magnitude ALU slice.
// Encoding: bit 8 = sign, bits 7:0 = magnitude.
package alu9_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] mag;
  } sm9_t;

  localparam logic       OP_ADD      = 1'b0;
  localparam logic       OP_SUB      = 1'b1;
  localparam logic [7:0] SM9_MAG_MAX = 8'hFF;

  // A value is zero regardless of its sign bit (-0 counts as 0).
  function automatic logic sm9_is_zero(input sm9_t v);
    return (v.mag == 8'h00);
  endfunction

endpackage

// File: rtl/sm9_addsub.sv
// Combinational 9-bit sign-magnitude add/subtract.
// Optional macro ALU9_SAT_EN: when defined, an overflowing magnitude
// saturates to 8'hFF; otherwise it wraps to the low 8 bits of the sum.
// The overflow flag is raised in both builds.
module sm9_addsub
  import alu9_pkg::*;
(
  input  sm9_t a,
  input  sm9_t b,
  input  logic op,
  output sm9_t result,
  output logic ovf
);

  logic       a_sign_s;
  logic       b_sign_s;
  logic       b_flip_s;
  logic [8:0] sum_s;
  logic [7:0] diff_ab_s;
  logic [7:0] diff_ba_s;

  // -0 is folded to +0 before the sign comparison.
  assign a_sign_s  = a.sign & ~sm9_is_zero(a);
  assign b_sign_s  = b_flip_s & ~sm9_is_zero(b);
  assign sum_s     = {1'b0, a.mag} + {1'b0, b.mag};
  assign diff_ab_s = a.mag - b.mag;
  assign diff_ba_s = b.mag - a.mag;

  // Subtraction is an add with B's sign inverted.
  always_comb begin
    b_flip_s = b.sign;
    case (op)
      OP_ADD:  b_flip_s = b.sign;
      OP_SUB:  b_flip_s = ~b.sign;
      default: b_flip_s = b.sign;
    endcase
  end

  // Sign-magnitude add: same signs add magnitudes, differing signs subtract
  // smaller from larger; a true zero result is always +0.
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    if (a_sign_s == b_sign_s) begin
      ovf = sum_s[8];
      if (sum_s[8]) begin
`ifdef ALU9_SAT_EN
        result.mag = SM9_MAG_MAX;
`else
        result.mag = sum_s[7:0];
`endif
        result.sign = a_sign_s;
      end else begin
        result.mag  = sum_s[7:0];
        result.sign = a_sign_s & (sum_s[7:0] != 8'h00);
      end
    end else begin
      if (a.mag >= b.mag) begin
        result.mag  = diff_ab_s;
        result.sign = a_sign_s & (diff_ab_s != 8'h00);
      end else begin
        result.mag  = diff_ba_s;
        result.sign = b_sign_s;
      end
    end
  end

endmodule

// File: rtl/alu9_rr_scheduler.sv
// Round-robin scheduler sharing one sm9_addsub slice between NUM_REQ
// requesters, with a one-entry registered result stage and backpressure.
// Optional macro ALU9_SAT_EN (saturating overflow) is handled in sm9_addsub.
module alu9_rr_scheduler
  import alu9_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ*9-1:0] req_a,
  input  logic [NUM_REQ*9-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [8:0]           resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 resp_ovf,
  output logic [CNT_W-1:0]     op_count
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]         state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [8:0]         resp_data_r;
  logic [ID_W-1:0]    resp_id_r;
  logic               resp_ovf_r;
  logic [CNT_W-1:0]   op_count_r;

  logic [8:0]         a_arr_s [NUM_REQ];
  logic [8:0]         b_arr_s [NUM_REQ];
  int                 idx_int_s;
  logic [ID_W-1:0]    idx_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               grant_any_s;
  logic [NUM_REQ-1:0] grant_oh_s;
  logic               can_accept_s;
  logic               fire_s;
  logic               consume_s;
  sm9_t               op_a_s;
  sm9_t               op_b_s;
  sm9_t               alu_res_s;
  logic               alu_ovf_s;

  // Split the flat operand buses into per-requester words.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr_s[k] = req_a[k*9 +: 9];
    assign b_arr_s[k] = req_b[k*9 +: 9];
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_any_s = 1'b0;
    grant_id_s  = '0;
    idx_int_s   = 0;
    idx_s       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_int_s = (int'(ptr_r) + i) % NUM_REQ;
      idx_s     = ID_W'(idx_int_s);
      if (!grant_any_s && req_valid[idx_s]) begin
        grant_any_s = 1'b1;
        grant_id_s  = idx_s;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // One-hot form of the winning requester.
  always_comb begin
    grant_oh_s = '0;
    if (grant_any_s) begin
      grant_oh_s[grant_id_s] = 1'b1;
    end else begin
      grant_oh_s = '0;
    end
  end

  // The result register can take a new value when empty or being drained.
  assign can_accept_s = (state_r == ST_EMPTY) || resp_ready;
  assign req_ready    = (can_accept_s && rst_n) ? grant_oh_s : '0;
  assign fire_s       = grant_any_s && can_accept_s && rst_n;
  assign consume_s    = (state_r == ST_FULL) && resp_ready;

  assign op_a_s = a_arr_s[grant_id_s];
  assign op_b_s = b_arr_s[grant_id_s];

  sm9_addsub u_alu (
    .a      (op_a_s),
    .b      (op_b_s),
    .op     (req_op[grant_id_s]),
    .result (alu_res_s),
    .ovf    (alu_ovf_s)
  );

  // Result-stage occupancy: fire fills (even while draining), consume empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: state_r <= fire_s ? ST_FULL : ST_EMPTY;
        ST_FULL:  state_r <= (fire_s || !consume_s) ? ST_FULL : ST_EMPTY;
        default:  state_r <= ST_EMPTY;
      endcase
    end
  end

  // Capture the ALU result and the grant pointer on every fire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_data_r <= 9'h000;
      resp_id_r   <= '0;
      resp_ovf_r  <= 1'b0;
      ptr_r       <= ID_W'(NUM_REQ - 1);
    end else if (fire_s) begin
      resp_data_r <= alu_res_s;
      resp_id_r   <= grant_id_s;
      resp_ovf_r  <= alu_ovf_s;
      ptr_r       <= grant_id_s;
    end else begin
      resp_data_r <= resp_data_r;
      resp_id_r   <= resp_id_r;
      resp_ovf_r  <= resp_ovf_r;
      ptr_r       <= ptr_r;
    end
  end

  // Count results taken by the consumer; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count_r <= '0;
    end else if (consume_s) begin
      op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign resp_valid = (state_r == ST_FULL);
  assign resp_data  = resp_data_r;
  assign resp_id    = resp_id_r;
  assign resp_ovf   = resp_ovf_r;
  assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu9_rr_scheduler.sv
// Directed self-checking bench for alu9_rr_scheduler (NUM_REQ = 4).
module tb_alu9_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_op;
  logic [35:0] req_a;
  logic [35:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [8:0]  resp_data;
  logic [1:0]  resp_id;
  logic        resp_ovf;
  logic [15:0] op_count;

  int checks   = 0;
  int failures = 0;

  alu9_rr_scheduler #(.NUM_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ovf   (resp_ovf),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  // Arithmetic vectors: requester, op, A, B, expected result, expected ovf.
  int         t_k   [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  logic       t_op  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [8:0] t_a   [8] = '{9'h0C8, 9'h1F0, 9'h100, 9'h0FF, 9'h003, 9'h003, 9'h103, 9'h105};
  logic [8:0] t_b   [8] = '{9'h164, 9'h120, 9'h100, 9'h0FF, 9'h002, 9'h102, 9'h002, 9'h005};
`ifdef ALU9_SAT_EN
  logic [8:0] t_exp [8] = '{9'h0FF, 9'h1FF, 9'h000, 9'h000, 9'h001, 9'h005, 9'h101, 9'h000};
`else
  logic [8:0] t_exp [8] = '{9'h02C, 9'h110, 9'h000, 9'h000, 9'h001, 9'h005, 9'h101, 9'h000};
`endif
  logic       t_ovf [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic op, input logic [8:0] a, input logic [8:0] b);
    req_op[k]       = op;
    req_a[k*9 +: 9] = a;
    req_b[k*9 +: 9] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'h0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 4'hF;
    req_op     = 4'h0;
    req_a      = 36'h0;
    req_b      = 36'h0;
    resp_ready = 1'b1;
    tick();
    tick();
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_data !== 9'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", resp_data); end
    checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", resp_id); end
    checks++; if (resp_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", resp_ovf); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", op_count); end
    req_valid = 4'h0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_arith();
    int cnt = 0;
    logic [3:0] mask;
    resp_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      mask = 4'b0001 << t_k[n];
      set_req(t_k[n], t_op[n], t_a[n], t_b[n]);
      req_valid = mask;
      #1;
      checks++; if (req_ready !== mask) begin failures++; $display("FAIL arith_ready[%0d] got=%b exp=%b", n, req_ready, mask); end
      tick();
      checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL arith_valid[%0d] got=%b exp=1", n, resp_valid); end
      checks++; if (resp_data !== t_exp[n]) begin failures++; $display("FAIL arith_data[%0d] got=%h exp=%h", n, resp_data, t_exp[n]); end
      checks++; if (resp_id !== 2'(t_k[n])) begin failures++; $display("FAIL arith_id[%0d] got=%0d exp=%0d", n, resp_id, t_k[n]); end
      checks++; if (resp_ovf !== t_ovf[n]) begin failures++; $display("FAIL arith_ovf[%0d] got=%b exp=%b", n, resp_ovf, t_ovf[n]); end
      checks++; if (op_count !== 16'(cnt)) begin failures++; $display("FAIL arith_cnt_pre[%0d] got=%0d exp=%0d", n, op_count, cnt); end
      req_valid = 4'h0;
      tick();
      cnt++;
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL arith_drain[%0d] got=%b exp=0", n, resp_valid); end
      checks++; if (op_count !== 16'(cnt)) begin failures++; $display("FAIL arith_cnt[%0d] got=%0d exp=%0d", n, op_count, cnt); end
    end
  endtask

  task automatic test_back_to_back();
    int g;
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 1'b0, 9'(k + 1), 9'h010);
    resp_ready = 1'b1;
    req_valid  = 4'hF;
    for (int i = 0; i < 5; i++) begin
      g = i % 4;
      #1;
      checks++; if (req_ready !== 4'(1 << g)) begin failures++; $display("FAIL b2b_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << g)); end
      tick();
      checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, resp_valid); end
      checks++; if (resp_id !== 2'(g)) begin failures++; $display("FAIL b2b_id[%0d] got=%0d exp=%0d", i, resp_id, g); end
      checks++; if (resp_data !== 9'(17 + g)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, resp_data, 9'(17 + g)); end
    end
    req_valid = 4'h0;
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", resp_valid); end
    checks++; if (op_count !== 16'd5) begin failures++; $display("FAIL b2b_count got=%0d exp=5", op_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b0, 9'h011, 9'h022);
    set_req(1, 1'b1, 9'h050, 9'h010);
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready); end
      checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, resp_valid); end
      checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL bp_id[%0d] got=%0d exp=0", i, resp_id); end
      checks++; if (resp_data !== 9'h033) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=033", i, resp_data); end
      tick();
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release_ready got=%b exp=0010", req_ready); end
    tick();
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL bp_reload_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_id !== 2'd1) begin failures++; $display("FAIL bp_reload_id got=%0d exp=1", resp_id); end
    checks++; if (resp_data !== 9'h040) begin failures++; $display("FAIL bp_reload_data got=%h exp=040", resp_data); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL bp_count1 got=%0d exp=1", op_count); end
    req_valid = 4'h0;
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", resp_valid); end
    checks++; if (op_count !== 16'd2) begin failures++; $display("FAIL bp_count2 got=%0d exp=2", op_count); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(1, 1'b0, 9'h001, 9'h001);
    resp_ready = 1'b1;
    req_valid  = 4'b0010;
    tick();
    tick();
    resp_ready = 1'b0;
    req_valid  = 4'h0;
    tick();
    checks++; if (resp_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", resp_valid); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL mid_pre_count got=%0d exp=1", op_count); end
    set_req(0, 1'b0, 9'h004, 9'h004);
    set_req(2, 1'b0, 9'h020, 9'h001);
    req_valid = 4'b0101;
    rst_n     = 1'b0;
    #1;
    checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", resp_valid); end
    checks++; if (op_count !== 16'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", op_count); end
    checks++; if (resp_data !== 9'h000) begin failures++; $display("FAIL mid_data got=%h exp=000", resp_data); end
    checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL mid_id got=%0d exp=0", resp_id); end
    rst_n      = 1'b1;
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_grant got=%b exp=0001", req_ready); end
    tick();
    checks++; if (resp_id !== 2'd0) begin failures++; $display("FAIL mid_resp_id got=%0d exp=0", resp_id); end
    checks++; if (resp_data !== 9'h008) begin failures++; $display("FAIL mid_resp_data got=%h exp=008", resp_data); end
    req_valid = 4'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
